// File: rtl/led_pattern_sequencer_if.sv
// Handshake-free control/status bundle between the board top level and the LED sequencer.
// The master side drives mode, enable and brightness; the slave side returns the LED word and step pulse.
interface led_pattern_sequencer_if #(
   parameter int PWM_BITS = 4
);
   logic                enable;
   logic [1:0]          mode;
   logic [PWM_BITS-1:0] brightness;
   logic [7:0]          leds;
   logic                step_tick;

   modport master (
      output enable,
      output mode,
      output brightness,
      input  leds,
      input  step_tick
   );

   modport slave (
      input  enable,
      input  mode,
      input  brightness,
      output leds,
      output step_tick
   );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Animated LED pattern driver: prescaled step ticks advance a mode FSM,
// and a shared PWM dims every lit LED before the registered output.
module led_pattern_sequencer #(
   parameter int STEP_DIV = 1000000,
   parameter int PWM_BITS = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   led_pattern_sequencer_if.slave bus
);

   localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_SHIFT     = 3'd1,
      S_BOUNCE_UP = 3'd2,
      S_BOUNCE_DN = 3'd3,
      S_BLINK     = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_nx_s;
   logic [7:0]          pattern_r;
   logic [7:0]          pattern_nx_s;
   logic [DIV_W-1:0]    div_cnt_r;
   logic [PWM_BITS-1:0] pwm_cnt_r;
   logic [7:0]          leds_r;
   logic                step_tick_r;
   logic                tick_s;
   logic                pwm_on_s;

   // Both bounce directions report the same user-visible mode.
   function automatic logic [1:0] mode_of(input state_t s);
      logic [1:0] m;
      case (s)
         S_OFF:       m = 2'd0;
         S_SHIFT:     m = 2'd1;
         S_BOUNCE_UP: m = 2'd2;
         S_BOUNCE_DN: m = 2'd2;
         S_BLINK:     m = 2'd3;
         default:     m = 2'd0;
      endcase
      return m;
   endfunction

   // The counter only reaches its top value while enabled, so a tick
   // already due still lands in the cycle enable drops.
   assign tick_s   = (div_cnt_r == DIV_W'(STEP_DIV - 1));
   assign pwm_on_s = (pwm_cnt_r < bus.brightness) ||
                     (bus.brightness == {PWM_BITS{1'b1}});

   // Step prescaler and registered step pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt_r   <= {DIV_W{1'b0}};
         step_tick_r <= 1'b0;
      end else begin
         step_tick_r <= tick_s;
         if (bus.enable && !tick_s) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
         end else begin
            div_cnt_r <= {DIV_W{1'b0}};
         end
      end
   end

   // Free-running PWM counter and dimmed LED output register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pwm_cnt_r <= {PWM_BITS{1'b0}};
         leds_r    <= 8'h00;
      end else begin
         pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
         leds_r    <= pattern_r & {8{pwm_on_s}};
      end
   end

   // Mode FSM state and pattern registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= S_OFF;
         pattern_r <= 8'h00;
      end else begin
         state_r   <= state_nx_s;
         pattern_r <= pattern_nx_s;
      end
   end

   // Next-state and next-pattern: a pending mode change beats advancing.
   always_comb begin
      state_nx_s   = state_r;
      pattern_nx_s = pattern_r;
      if (tick_s) begin
         if (bus.mode != mode_of(state_r)) begin
            case (bus.mode)
               2'd0: begin
                  state_nx_s   = S_OFF;
                  pattern_nx_s = 8'h00;
               end
               2'd1: begin
                  state_nx_s   = S_SHIFT;
                  pattern_nx_s = 8'h01;
               end
               2'd2: begin
                  state_nx_s   = S_BOUNCE_UP;
                  pattern_nx_s = 8'h01;
               end
               2'd3: begin
                  state_nx_s   = S_BLINK;
                  pattern_nx_s = 8'hFF;
               end
               default: begin
                  state_nx_s   = S_OFF;
                  pattern_nx_s = 8'h00;
               end
            endcase
         end else begin
            case (state_r)
               S_OFF: begin
                  pattern_nx_s = 8'h00;
               end
               S_SHIFT: begin
                  pattern_nx_s = {pattern_r[6:0], pattern_r[7]};
               end
               S_BOUNCE_UP: begin
                  pattern_nx_s = {pattern_r[6:0], 1'b0};
                  if (pattern_r == 8'h40) begin
                     state_nx_s = S_BOUNCE_DN;
                  end else begin
                     state_nx_s = S_BOUNCE_UP;
                  end
               end
               S_BOUNCE_DN: begin
                  pattern_nx_s = {1'b0, pattern_r[7:1]};
                  if (pattern_r == 8'h02) begin
                     state_nx_s = S_BOUNCE_UP;
                  end else begin
                     state_nx_s = S_BOUNCE_DN;
                  end
               end
               S_BLINK: begin
                  pattern_nx_s = ~pattern_r;
               end
               default: begin
                  state_nx_s   = S_OFF;
                  pattern_nx_s = 8'h00;
               end
            endcase
         end
      end else begin
         state_nx_s   = state_r;
         pattern_nx_s = pattern_r;
      end
   end

   assign bus.leds      = leds_r;
   assign bus.step_tick = step_tick_r;

endmodule
